// File: rtl/plot_frame_buffer.sv
// Double-buffered sample store between the plotting datapath and the VGA controller.
// The fill bank is written through a valid/ready port; banks swap only on a vsync falling edge.
module plot_frame_buffer #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_valid_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  wr_last_i,
    output logic                  wr_ready_o,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o,
    input  logic                  vs_i,
    output logic [DEPTH_LOG2:0]   frame_len_o,
    output logic                  swap_o,
    output logic                  state_o
);

    // Write handshake: a word transfers on a rising clk_i edge where
    // wr_valid_i && wr_ready_o; wr_data_i/wr_last_i are sampled only then.
    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LAST_CNT = (DEPTH_LOG2 + 1)'(DEPTH - 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0]      bank0 [DEPTH];
    logic [WIDTH-1:0]      bank1 [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   wr_cnt;
    logic                  front_sel;
    logic                  vs_q;

    logic wr_fire;
    logic frame_done;
    logic vs_edge;
    logic do_swap;

    assign wr_fire    = wr_valid_i & wr_ready_o;
    assign frame_done = wr_fire & (wr_last_i | (wr_cnt == LAST_CNT));
    assign vs_edge    = vs_q & ~vs_i;
    assign do_swap    = (state == PENDING) & vs_edge;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // An edge arriving in FILL is ignored, even on the completing handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (frame_done) state_nxt = PENDING;
            PENDING: if (vs_edge)    state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        wr_ready_o = (state == FILL) & ~rst_i;
        state_o    = state;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vs_q        <= 1'b1;
            wr_ptr      <= '0;
            wr_cnt      <= '0;
            front_sel   <= 1'b0;
            frame_len_o <= '0;
            swap_o      <= 1'b0;
        end else begin
            vs_q   <= vs_i;
            swap_o <= do_swap;
            if (do_swap) begin
                front_sel   <= ~front_sel;
                frame_len_o <= wr_cnt;
                wr_ptr      <= '0;
                wr_cnt      <= '0;
            end else if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                // Hold the pointer on the completing word so a full frame never wraps it.
                if (!frame_done) wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Back bank is the one not selected for display.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            if (front_sel) bank0[wr_ptr] <= wr_data_i;
            else           bank1[wr_ptr] <= wr_data_i;
        end
    end

    // Words beyond the displayed frame length read as zero; stale RAM is never exposed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
        end else if ({1'b0, rd_addr_i} < frame_len_o) begin
            rd_data_o <= front_sel ? bank1[rd_addr_i] : bank0[rd_addr_i];
        end else begin
            rd_data_o <= '0;
        end
    end

endmodule
